// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory slave with req/ack handshake.
// Requests are latched in IDLE and completed with a one-cycle ack. Accesses
// that are misaligned or outside 4*DEPTH bytes complete with err and rdata=0.
// Optional feature macro DMEM_WAIT_STATE_EN: adds a WAIT state that delays
// ack by WAIT_CYCLES cycles. Without it, ack follows the accepting edge.
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  // Elaboration-time guard on the legal parameter ranges.
  if (WAIT_CYCLES > 15 || DEPTH > 64 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_param_check
    $error("data_mem_responder: WAIT_CYCLES must be 0..15, DEPTH a power of two in 2..64");
  end

`ifdef DMEM_WAIT_STATE_EN
  localparam logic [3:0] W_EFF = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

  state_t      state;
  logic [31:0] mem [DEPTH];

  // Request being committed this edge (live inputs when entering RESP from IDLE)
  logic          go_resp;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          illegal;
  logic [AW-1:0] idx;

  // Select the committing request and decide whether this edge enters RESP.
  always_comb begin
    c_we    = we;
    c_addr  = addr;
    c_wdata = wdata;
    go_resp = 1'b0;
    case (state)
`ifdef DMEM_WAIT_STATE_EN
      IDLE: go_resp = req && (W_EFF == 4'd0);
      WAIT: begin
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        go_resp = (cnt == 4'd1);
      end
`else
      IDLE: go_resp = req;
`endif
      default: go_resp = 1'b0;
    endcase
  end

  // Legality and word index of the committing request.
  always_comb begin
    illegal = (c_addr[1:0] != 2'b00) || (c_addr >= LIMIT);
    idx     = c_addr[AW+1:2];
  end

  // Control FSM with registered ack/busy/err and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
`ifdef DMEM_WAIT_STATE_EN
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
`endif
      if (go_resp) begin
        state <= RESP;
        ack   <= 1'b1;
        busy  <= 1'b1;
        err   <= illegal;
        if (illegal)
          rdata <= '0;
        else if (!c_we)
          rdata <= mem[idx];
`ifdef DMEM_WAIT_STATE_EN
        cnt <= '0;
`endif
      end else begin
        case (state)
`ifdef DMEM_WAIT_STATE_EN
          IDLE: begin
            if (req) begin
              state <= WAIT;
              cnt   <= W_EFF;
              busy  <= 1'b1;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
`else
          IDLE: ;
`endif
          RESP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Memory array: cleared by reset, written only by a legal store entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[AW'(i)] <= '0;
    end else if (go_resp && c_we && !illegal) begin
      mem[idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (WAIT_CYCLES=2, DEPTH=64).
// Expected ack latency is 2 when DMEM_WAIT_STATE_EN is defined, else 0.
module tb_data_mem_responder;

`ifdef DMEM_WAIT_STATE_EN
  localparam int W_EXP = 2;
`else
  localparam int W_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy, err;

  int tests = 0;
  int fails = 0;

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-schedule model: a request accepted at edge A keeps busy high
  // through edge A+W, completes (ack, err, data effect) at edge A+W, and the
  // following edge returns to idle without accepting.
  logic [31:0] m_mem [64];
  logic [31:0] m_rdata;
  bit          m_ack, m_err, m_busy, pending;
  int          cyc, acc;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_rdata = '0; m_ack = 0; m_err = 0; m_busy = 0; pending = 0; cyc = 0; acc = 0;
    end else begin
      cyc++;
      m_ack = 0; m_err = 0;
      if (pending) begin
        if (cyc == acc + W_EXP + 1) pending = 0;
      end else if (req) begin
        pending = 1; acc = cyc; p_we = we; p_addr = addr; p_wdata = wdata;
      end
      if (pending && cyc == acc + W_EXP) begin
        m_ack = 1;
        m_err = (p_addr % 4 != 0) || (p_addr >= 256);
        if (m_err) m_rdata = '0;
        else if (p_we) m_mem[p_addr / 4] = p_wdata;
        else m_rdata = m_mem[p_addr / 4];
      end
      m_busy = pending;
    end
  end

  // Every cycle: DUT outputs must match the model.
  always @(posedge clk) begin
    #1;
    chk("ack", ack, m_ack);
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
    chk("rdata", rdata, m_rdata);
  end

  task automatic wait_ack(output int n, output bit got);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (ack) got = 1;
    end
  endtask

  // One handshake with hand-computed expectations for err, rdata, latency, busy length.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit e_err, input bit ck_rd, input logic [31:0] e_rd);
    int  n;
    int  busy_n;
    bit  got;
    n = 0; busy_n = 0; got = 0;
    @(negedge clk);
    req = 1; we = w; addr = a; wdata = d;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (busy) busy_n++;
      if (ack) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout: no ack for addr %h within 40 cycles", a);
    end else begin
      chk("xfer_err", err, e_err);
      if (ck_rd) chk("xfer_rdata", rdata, e_rd);
      chk("ack_latency", n - 1, W_EXP);
    end
    @(negedge clk);
    req = 0;
    @(posedge clk); #1;
    if (busy) busy_n++;
    chk("busy_cycles", busy_n, W_EXP + 1);
  endtask

  initial begin
    int  n, gap;
    bit  got;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) rst = 1'b0;

    // Basic store/load; first request accepted on the first edge after reset
    xfer(1, 32'h10, 32'h12345678, 0, 0, '0);
    xfer(0, 32'h10, '0, 0, 1, 32'h12345678);
    // Misaligned load, then confirm memory intact
    xfer(0, 32'h13, '0, 1, 1, 32'h0);
    xfer(0, 32'h10, '0, 0, 1, 32'h12345678);
    // Out-of-range store: err, no write
    xfer(1, 32'h100, 32'hAAAA5555, 1, 1, 32'h0);
    xfer(0, 32'h0, '0, 0, 1, 32'h0);
    // Last legal word
    xfer(1, 32'hFC, 32'h5A5A0FF0, 0, 0, '0);
    xfer(0, 32'hFC, '0, 0, 1, 32'h5A5A0FF0);

    // Reset one cycle after accepting a store
    @(negedge clk);
    req = 1; we = 1; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1; req = 0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    @(negedge clk) rst = 0;
    xfer(0, 32'h20, '0, 0, 1, 32'h0);
    xfer(0, 32'h10, '0, 0, 1, 32'h0);

    // req held across ack: two loads separated by one idle cycle
    xfer(1, 32'h4, 32'h11111111, 0, 0, '0);
    xfer(1, 32'h8, 32'h22222222, 0, 0, '0);
    @(negedge clk);
    req = 1; we = 0; addr = 32'h4;
    wait_ack(n, got);
    chk("b2b_first_ack", got, 1);
    chk("b2b_first_rdata", rdata, 32'h11111111);
    @(negedge clk) addr = 32'h8;
    wait_ack(gap, got);
    chk("b2b_second_ack", got, 1);
    chk("b2b_gap", gap, W_EXP + 2);
    chk("b2b_second_rdata", rdata, 32'h22222222);
    @(negedge clk) req = 0;
    @(posedge clk); #1;

    // Store then load at 0x3C
    xfer(1, 32'h3C, 32'hCAFEF00D, 0, 0, '0);
    xfer(0, 32'h3C, '0, 0, 1, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
